// File: rtl/snake_line_renderer.sv
// Builds a 40-cell head/body occupancy mask for the next grid row during horizontal blanking, then paints pixels from it.
// Latency: colour is registered, 1 pixel strobe after hCount/vCount are sampled; a row scan takes N+2 clocks from trigger to DONE.
// Backpressure: none; the scan runs every clock regardless of pix_en, and a swap that overtakes an unfinished scan sets line_late.
//
// Ports:
//   clock, reset_n         - system clock, asynchronous active-low reset
//   pix_en, hCount, vCount - pixel strobe and VGA raster position
//   seg_count              - valid segment count (clamped to MAX_SEG, latched at scan start)
//   seg_addr, seg_x, seg_y - segment RAM read port (data returns one clock after the address)
//   food_x, food_y         - food cell, used live
//   Red, Green, Blue       - registered pixel colour
//   line_late              - sticky flag, scan overrun at a line swap
module snake_line_renderer #(
  parameter int MAX_SEG  = 64,
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pix_en,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic [6:0] seg_count,
  output logic [5:0] seg_addr,
  input  logic [5:0] seg_x,
  input  logic [4:0] seg_y,
  input  logic [5:0] food_x,
  input  logic [4:0] food_y,
  output logic [3:0] Red,
  output logic [3:0] Green,
  output logic [3:0] Blue,
  output logic       line_late
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} scanStateT;

  localparam logic [9:0]  hActiveL = 10'(H_ACTIVE);
  localparam logic [9:0]  hLastL   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  vActiveL = 10'(V_ACTIVE);
  localparam logic [10:0] vActiveW = 11'(V_ACTIVE);
  localparam logic [6:0]  maxSegL  = 7'(MAX_SEG);
  localparam logic [5:0]  gridWL   = 6'(GRID_W);
  localparam logic [5:0]  gridHL   = 6'(GRID_H);

  scanStateT         state, stateNext;
  logic [10:0]       nextLine;
  logic              nextVisible;
  logic              trigger;
  logic              swap;
  logic              lastIssue;
  logic              scanning;
  logic [6:0]        segClamped;
  logic [6:0]        nSeg;
  logic [4:0]        scanRow;
  logic              rdVld;
  logic              rdHead;
  logic [GRID_W-1:0] backHead, backBody, frontHead, frontBody;
  logic [5:0]        pixCol, pixRow;
  logic [11:0]       pixColour;

  // One extra bit so vCount=1023 cannot wrap to a visible line.
  assign nextLine    = {1'b0, vCount} + 11'd1;
  assign nextVisible = nextLine < vActiveW;
  assign trigger     = pix_en && (hCount == hActiveL) && nextVisible;
  assign swap        = pix_en && (hCount == hLastL);
  assign segClamped  = (seg_count > maxSegL) ? maxSegL : seg_count;
  assign lastIssue   = ({1'b0, seg_addr} == (nSeg - 7'd1));
  assign scanning    = (state == SCAN) || (state == DRAIN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (trigger) stateNext = (segClamped == 7'd0) ? DRAIN : SCAN;
      SCAN:    if (lastIssue) stateNext = DRAIN;
      DRAIN:   stateNext = DONE;
      default: stateNext = state;
    endcase
    // The swap always wins: an unfinished scan is abandoned with its partial masks.
    if (swap) stateNext = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg_addr  <= '0;
      nSeg      <= '0;
      scanRow   <= '0;
      rdVld     <= 1'b0;
      rdHead    <= 1'b0;
      backHead  <= '0;
      backBody  <= '0;
      frontHead <= '0;
      frontBody <= '0;
      line_late <= 1'b0;
    end else begin
      // Tracks the address issued this clock; its data arrives next clock.
      rdVld  <= (state == SCAN);
      rdHead <= (seg_addr == 6'd0);

      if (state == IDLE && trigger) begin
        backHead <= '0;
        backBody <= '0;
        nSeg     <= segClamped;
        scanRow  <= nextLine[8:4];
        if (segClamped != 7'd0) seg_addr <= 6'd0;
      end else if (rdVld && scanning && seg_y == scanRow && seg_x < gridWL) begin
        if (rdHead) backHead[seg_x] <= 1'b1;
        else        backBody[seg_x] <= 1'b1;
      end

      if (state == SCAN && !lastIssue) seg_addr <= seg_addr + 6'd1;

      if (swap) begin
        frontHead <= nextVisible ? backHead : '0;
        frontBody <= nextVisible ? backBody : '0;
        if (scanning) line_late <= 1'b1;
      end
    end
  end

  assign pixCol = hCount[9:4];
  assign pixRow = vCount[9:4];

  always_comb begin
    pixColour = 12'h000;
    if (hCount < hActiveL && vCount < vActiveL && pixRow < gridHL) begin
      if (frontHead[pixCol])                                   pixColour = 12'h0F0;
      else if (frontBody[pixCol])                              pixColour = 12'hFFF;
      else if (pixCol == food_x && pixRow == {1'b0, food_y})   pixColour = 12'hF00;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      Red   <= '0;
      Green <= '0;
      Blue  <= '0;
    end else if (pix_en) begin
      {Red, Green, Blue} <= pixColour;
    end
  end

endmodule
